// File: rtl/jk_sync_counter.sv
// Synchronous modulo-MOD up/down counter built from one JK flip-flop stage per bit.
// Define JKCNT_SAT_EN to saturate at the ends of the range instead of wrapping.

module jk_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else begin
      case ({j, k})
        2'b10:   q <= 1'b1;
        2'b01:   q <= 1'b0;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qb = ~q;
endmodule

module jk_sync_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] j, k, ld_val, lo_ones, lo_zeros, tgl;
  logic             at_term;

  assign at_term = up ? (q == MAXV) : (q == '0);
  assign tc      = en & ~load & at_term;
  assign ld_val  = (d > MAXV) ? MAXV : d;

  // Ripple-free carry/borrow terms: stage i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    lo_ones     = '0;
    lo_zeros    = '0;
    lo_ones[0]  = 1'b1;
    lo_zeros[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      lo_ones[i]  = lo_ones[i-1] & q[i-1];
      lo_zeros[i] = lo_zeros[i-1] & ~q[i-1];
    end
  end

  assign tgl = up ? lo_ones : lo_zeros;

  always_comb begin
    j = '0;
    k = '0;
    if (load) begin
      j = ld_val;
      k = ~ld_val;
    end else if (en) begin
      if (at_term) begin
`ifdef JKCNT_SAT_EN
        j = '0;
        k = '0;
`else
        // Wrap target is forced with set/reset, not toggle, since MOD need not be a power of 2.
        j = up ? '0 : MAXV;
        k = ~j;
`endif
      end else begin
        j = tgl;
        k = tgl;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    jk_stage u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j[i]),
      .k     (k[i]),
      .q     (q[i]),
      .qb    (qb[i])
    );
  end

  // tc is exactly the wrap/saturation attempt condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf <= 1'b0;
    else if (load) ovf <= 1'b0;
    else if (tc)   ovf <= 1'b1;
  end
endmodule

// File: tb/tb_jk_sync_counter.sv
// Randomized self-checking bench for jk_sync_counter against an integer reference model.
// Honors JKCNT_SAT_EN so the same bench covers both wrap and saturate builds.

module tb_jk_sync_counter;
  localparam int WIDTH = 4;
  localparam int MOD   = 10;
`ifdef JKCNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0, rst_n = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic [WIDTH-1:0] q, qb;
  logic             tc, ovf;

  int ncmp = 0, nerr = 0;
  int mq   = 0;
  bit movf = 1'b0;

  jk_sync_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .up    (up),
    .load  (load),
    .d     (d),
    .q     (q),
    .qb    (qb),
    .tc    (tc),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Reference: next count from the arithmetic rules.
  function automatic int m_next(int cur);
    if (load) return (int'(d) >= MOD) ? MOD - 1 : int'(d);
    if (!en)  return cur;
    if (up)   return (cur == MOD - 1) ? (SAT ? cur : 0) : cur + 1;
    return (cur == 0) ? (SAT ? 0 : MOD - 1) : cur - 1;
  endfunction

  function automatic bit m_tc();
    return en && !load && (up ? (mq == MOD - 1) : (mq == 0));
  endfunction

  task automatic drive(input bit e, input bit u, input bit l, input int dv);
    en = e; up = u; load = l; d = WIDTH'(dv);
    #1;
  endtask

  task automatic tick();
    int nq;
    bit novf;
    nq   = m_next(mq);
    novf = load ? 1'b0 : (movf | m_tc());
    @(posedge clk);
    #1;
    mq   = nq;
    movf = novf;
  endtask

  task automatic test_reset();
    #1;
    ncmp++;
    if (q !== '0 || qb !== 4'b1111 || ovf !== 1'b0) begin
      $display("FAIL reset_init: q=%0d qb=%b ovf=%b, want q=0 qb=1111 ovf=0", q, qb, ovf);
      nerr++;
    end
    drive(1, 0, 0, 0);
    ncmp++;
    if (tc !== 1'b1) begin
      $display("FAIL reset_tc: tc=%b want 1", tc);
      nerr++;
    end
    rst_n = 1'b1;
    drive(0, 1, 1, 7);
    tick();
    drive(0, 1, 0, 0);
    ncmp++;
    if (q !== 4'd7) begin
      $display("FAIL reset_preload: q=%0d want 7", q);
      nerr++;
    end
    #2 rst_n = 1'b0;
    #1;
    ncmp++;
    if (q !== '0 || qb !== 4'b1111 || ovf !== 1'b0) begin
      $display("FAIL reset_async: q=%0d qb=%b ovf=%b, want q=0 qb=1111 ovf=0", q, qb, ovf);
      nerr++;
    end
    mq = 0; movf = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    drive(1, 1, 0, 0);
    for (int i = 0; i < 11; i++) begin
      ncmp++;
      if (tc !== m_tc()) begin
        $display("FAIL up_tc[%0d]: tc=%b want %b at q=%0d", i, tc, m_tc(), mq);
        nerr++;
      end
      tick();
      ncmp++;
      if (q !== WIDTH'(mq) || qb !== ~WIDTH'(mq) || ovf !== movf) begin
        $display("FAIL up_step[%0d]: q=%0d qb=%b ovf=%b, want q=%0d ovf=%b", i, q, qb, ovf, mq, movf);
        nerr++;
      end
    end
  endtask

  task automatic test_down_wrap();
    drive(0, 0, 1, 2);
    tick();
    ncmp++;
    if (q !== 4'd2 || ovf !== 1'b0) begin
      $display("FAIL down_load: q=%0d ovf=%b, want q=2 ovf=0", q, ovf);
      nerr++;
    end
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      ncmp++;
      if (tc !== m_tc()) begin
        $display("FAIL down_tc[%0d]: tc=%b want %b at q=%0d", i, tc, m_tc(), mq);
        nerr++;
      end
      tick();
      ncmp++;
      if (q !== WIDTH'(mq) || qb !== ~WIDTH'(mq) || ovf !== movf) begin
        $display("FAIL down_step[%0d]: q=%0d qb=%b ovf=%b, want q=%0d ovf=%b", i, q, qb, ovf, mq, movf);
        nerr++;
      end
    end
  endtask

  task automatic test_load();
    drive(1, 1, 1, 13);
    ncmp++;
    if (tc !== 1'b0) begin
      $display("FAIL load_tc: tc=%b want 0", tc);
      nerr++;
    end
    tick();
    ncmp++;
    if (q !== 4'd9 || ovf !== 1'b0) begin
      $display("FAIL load_clamp: q=%0d ovf=%b, want q=9 ovf=0", q, ovf);
      nerr++;
    end
    drive(0, 1, 1, 5);
    tick();
    ncmp++;
    if (q !== 4'd5 || qb !== 4'b1010) begin
      $display("FAIL load_5: q=%0d qb=%b, want q=5 qb=1010", q, qb);
      nerr++;
    end
  endtask

  task automatic test_hold();
    bit ovf0;
    drive(0, 1, 1, 6);
    tick();
    ovf0 = movf;
    for (int i = 0; i < 5; i++) begin
      drive(0, i[0], 0, 0);
      ncmp++;
      if (tc !== 1'b0) begin
        $display("FAIL hold_tc[%0d]: tc=%b want 0", i, tc);
        nerr++;
      end
      tick();
      ncmp++;
      if (q !== 4'd6 || qb !== 4'b1001 || ovf !== ovf0) begin
        $display("FAIL hold[%0d]: q=%0d qb=%b ovf=%b, want q=6 ovf=%b", i, q, qb, ovf, ovf0);
        nerr++;
      end
    end
  endtask

  task automatic test_sat_edges();
    int exp_up[3]   = SAT ? '{9, 9, 9} : '{9, 0, 1};
    int exp_down[2] = SAT ? '{0, 0}    : '{0, 9};
    drive(0, 1, 1, 8);
    tick();
    drive(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      ncmp++;
      if (q !== WIDTH'(exp_up[i]) || (i > 0 && ovf !== 1'b1)) begin
        $display("FAIL edge_up[%0d]: q=%0d ovf=%b, want q=%0d", i, q, ovf, exp_up[i]);
        nerr++;
      end
    end
    drive(0, 0, 1, 1);
    tick();
    drive(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      ncmp++;
      if (q !== WIDTH'(exp_down[i])) begin
        $display("FAIL edge_down[%0d]: q=%0d want %0d", i, q, exp_down[i]);
        nerr++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7) == 0,
            $urandom_range(0, 15));
      ncmp++;
      if (tc !== m_tc()) begin
        $display("FAIL rand_tc[%0d]: tc=%b want %b q=%0d", i, tc, m_tc(), mq);
        nerr++;
      end
      if ($urandom_range(0, 63) == 0) begin
        rst_n = 1'b0;
        #1;
        mq = 0; movf = 1'b0;
        ncmp++;
        if (q !== '0 || ovf !== 1'b0) begin
          $display("FAIL rand_rst[%0d]: q=%0d ovf=%b, want 0 0", i, q, ovf);
          nerr++;
        end
        rst_n = 1'b1;
        #1;
      end else begin
        tick();
        ncmp++;
        if (q !== WIDTH'(mq) || qb !== ~WIDTH'(mq) || ovf !== movf) begin
          $display("FAIL rand_step[%0d]: q=%0d qb=%b ovf=%b, want q=%0d ovf=%b", i, q, qb, ovf, mq, movf);
          nerr++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_hold();
    test_sat_edges();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
